// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the FIFO-draining UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic c_IDLE_LEVEL = 1'b1;

    function automatic int baud_cnt_width(input int clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_cnt.sv
// ============================================================================
// Module      : uart_baud_cnt
// Description : Bit-period counter; bit_tick marks the last cycle of each bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int c_W = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [c_W-1:0] c_LAST = c_W'(CLKS_PER_BIT - 1);

    logic [c_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bit_tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module      : fifo_uart_tx
// Description : Pops bytes from a FWFT FIFO and serializes them as UART frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  rd,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int c_BIT_W  = $clog2(DATA_WIDTH) + 1;
    localparam int c_STOP_W = $clog2(STOP_BITS) + 1;
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_STOP_W-1:0] c_STOP_LAST = c_STOP_W'(STOP_BITS - 1);

    tx_state_t               r_state;
    tx_state_t               w_state_next;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   w_shift_next;
    logic [c_BIT_W-1:0]      r_bit_cnt;
    logic [c_BIT_W-1:0]      w_bit_cnt_next;
    logic [c_STOP_W-1:0]     r_stop_cnt;
    logic [c_STOP_W-1:0]     w_stop_cnt_next;
    logic                    r_tx;
    logic                    w_tx_next;
    logic                    r_busy;
    logic                    w_bit_tick;
    logic                    w_baud_clear;
    logic                    w_stop_last;

    // Baud counter is held at zero while idle so a pop always starts a full start bit.
    assign w_baud_clear = (r_state == IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_baud_clear),
        .bit_tick (w_bit_tick)
    );

    assign w_stop_last = (r_state == STOP) && w_bit_tick && (r_stop_cnt == c_STOP_LAST);
    assign rd          = en && !empty && !reset && ((r_state == IDLE) || w_stop_last);

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_cnt_next  = r_bit_cnt;
        w_stop_cnt_next = r_stop_cnt;
        case (r_state)
            IDLE: begin
                if (rd) begin
                    w_state_next = START;
                    w_shift_next = read_data;
                end
            end
            START: begin
                if (w_bit_tick) begin
                    w_state_next   = DATA;
                    w_bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    w_shift_next = {1'b0, r_shift[DATA_WIDTH-1:1]};
                    if (r_bit_cnt == c_BIT_LAST) begin
                        w_state_next    = STOP;
                        w_bit_cnt_next  = '0;
                        w_stop_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_bit_tick) begin
                    if (r_stop_cnt == c_STOP_LAST) begin
                        w_stop_cnt_next = '0;
                        // Back-to-back pop skips IDLE so there is no gap between frames.
                        if (rd) begin
                            w_state_next = START;
                            w_shift_next = read_data;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_stop_cnt_next = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // The line level is registered from the next state so tx lines up with the FSM.
    always_comb begin
        w_tx_next = c_IDLE_LEVEL;
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = c_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_tx       <= c_IDLE_LEVEL;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_tx       <= w_tx_next;
            r_busy     <= (w_state_next != IDLE);
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = w_stop_last;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Directed self-checking bench for fifo_uart_tx (4 clks/bit, 1 and 2 stop bits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       en;
    logic       flush;

    // FWFT FIFO model feeding the single-stop-bit instance
    logic [7:0] mem [0:15];
    logic [4:0] wp = 5'd0;
    logic [4:0] rp = 5'd0;
    logic       empty;
    logic [7:0] read_data;
    logic       rd, tx, busy, frame_done;

    assign empty     = (wp == rp);
    assign read_data = mem[rp[3:0]];

    // One-entry source for the two-stop-bit instance
    logic [7:0] read_data2;
    logic [3:0] wp2 = 4'd0;
    logic [3:0] rp2 = 4'd0;
    logic       empty2;
    logic       rd2, tx2, busy2, fd2;

    assign empty2 = (wp2 == rp2);

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .en(en), .empty(empty), .read_data(read_data),
        .rd(rd), .tx(tx), .busy(busy), .frame_done(frame_done)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .empty(empty2), .read_data(read_data2),
        .rd(rd2), .tx(tx2), .busy(busy2), .frame_done(fd2)
    );

    int cyc = 0;
    int n_pops = 0;
    int last_pop_cyc = 0;
    int prev_pop_cyc = 0;
    int bad_rd = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (flush) rp <= wp;
        else if (rd) rp <= rp + 5'd1;
        if (rd2) rp2 <= rp2 + 4'd1;
        if (rd) begin
            n_pops       <= n_pops + 1;
            prev_pop_cyc <= last_pop_cyc;
            last_pop_cyc <= cyc;
        end
        if ((rd && empty) || (rd2 && empty2)) bad_rd <= bad_rd + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic push(input logic [7:0] b);
        mem[wp[3:0]] = b;
        wp = wp + 5'd1;
    endtask

    // Walks one frame from the cycle after the pop edge; optionally drops en at cycle drop_at.
    task automatic check_frame(input logic [7:0] b, input int nstop, input bit sel2,
                               input int drop_at, input string tag);
        int len;
        logic exp_tx, o_tx, o_busy, o_fd;
        len = (1 + 8 + nstop) * 4;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k <= 4) exp_tx = 1'b0;
            else if (k <= 36) exp_tx = b[(k - 5) / 4];
            else exp_tx = 1'b1;
            o_tx   = sel2 ? tx2   : tx;
            o_busy = sel2 ? busy2 : busy;
            o_fd   = sel2 ? fd2   : frame_done;
            n_cmp += 3;
            if (o_tx !== exp_tx) begin
                n_err++;
                $display("FAIL %s tx cycle %0d: got %b want %b", tag, k, o_tx, exp_tx);
            end
            if (o_busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s busy cycle %0d: got %b want 1", tag, k, o_busy);
            end
            if (o_fd !== (k == len)) begin
                n_err++;
                $display("FAIL %s frame_done cycle %0d: got %b want %b", tag, k, o_fd, (k == len));
            end
            if (k == drop_at) en = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag);
        n_cmp += 4;
        if (tx !== 1'b1) begin n_err++; $display("FAIL %s tx: got %b want 1", tag, tx); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy: got %b want 0", tag, busy); end
        if (frame_done !== 1'b0) begin n_err++; $display("FAIL %s frame_done: got %b want 0", tag, frame_done); end
        if (rd !== 1'b0) begin n_err++; $display("FAIL %s rd: got %b want 0", tag, rd); end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; flush = 1'b0; read_data2 = 8'h00;
        push(8'hA5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle("reset");
        end
    endtask

    task automatic test_single_frame();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rd !== 1'b1) begin n_err++; $display("FAIL single rd_after_reset: got %b want 1", rd); end
        check_frame(8'hA5, 1, 1'b0, 0, "single_A5");
        n_cmp++;
        if (n_pops !== 1) begin n_err++; $display("FAIL single pop_count: got %0d want 1", n_pops); end
        @(negedge clk);
        check_idle("single_after");
    endtask

    task automatic test_back_to_back();
        push(8'h00);
        push(8'hFF);
        #1;
        n_cmp++;
        if (rd !== 1'b1) begin n_err++; $display("FAIL b2b first_rd: got %b want 1", rd); end
        check_frame(8'h00, 1, 1'b0, 0, "b2b_00");
        n_cmp++;
        if (rd !== 1'b1) begin n_err++; $display("FAIL b2b second_rd_at_stop_last: got %b want 1", rd); end
        check_frame(8'hFF, 1, 1'b0, 0, "b2b_FF");
        n_cmp++;
        if (last_pop_cyc - prev_pop_cyc !== 40) begin
            n_err++;
            $display("FAIL b2b pop_spacing: got %0d want 40", last_pop_cyc - prev_pop_cyc);
        end
        @(negedge clk);
        check_idle("b2b_after");
    endtask

    task automatic test_en_drop();
        int pops_before;
        pops_before = n_pops;
        push(8'h3C);
        push(8'h77);
        check_frame(8'h3C, 1, 1'b0, 14, "endrop_3C");
        n_cmp += 2;
        if (rd !== 1'b0) begin n_err++; $display("FAIL endrop rd_at_stop_last: got %b want 0", rd); end
        if (empty !== 1'b0) begin n_err++; $display("FAIL endrop empty: got %b want 0", empty); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_idle("endrop_idle");
        end
        n_cmp++;
        if (n_pops !== pops_before + 1) begin
            n_err++;
            $display("FAIL endrop pop_count: got %0d want %0d", n_pops, pops_before + 1);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        en = 1'b1;
        push(8'h5A);
        for (int k = 1; k <= 18; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle("midreset");
        push(8'hC3);
        @(negedge clk);
        check_idle("midreset_hold");
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rd !== 1'b1) begin n_err++; $display("FAIL midreset rd_after_release: got %b want 1", rd); end
        check_frame(8'hC3, 1, 1'b0, 0, "midreset_C3");
        @(negedge clk);
        check_idle("midreset_after");
    endtask

    task automatic test_two_stop_bits();
        read_data2 = 8'h81;
        wp2 = wp2 + 4'd1;
        #1;
        n_cmp++;
        if (rd2 !== 1'b1) begin n_err++; $display("FAIL stop2 rd: got %b want 1", rd2); end
        check_frame(8'h81, 2, 1'b1, 0, "stop2_81");
        @(negedge clk);
        n_cmp += 3;
        if (tx2 !== 1'b1) begin n_err++; $display("FAIL stop2_after tx: got %b want 1", tx2); end
        if (busy2 !== 1'b0) begin n_err++; $display("FAIL stop2_after busy: got %b want 0", busy2); end
        if (rd2 !== 1'b0) begin n_err++; $display("FAIL stop2_after rd: got %b want 0", rd2); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_en_drop();
        test_reset_mid_frame();
        test_two_stop_bits();
        n_cmp++;
        if (bad_rd !== 0) begin n_err++; $display("FAIL rd_while_empty: got %0d want 0", bad_rd); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
